// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default widths for the two-port SRAM arbiter.
package sram_arb_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_e;
  typedef logic port_id_t;
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: turns the two request valids into a one-hot grant.
// Build option SRAM_ARB_RR_EN: round-robin on contention; otherwise port 0 has fixed priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  port_id_t   last_grant,
  output logic [1:0] grant
);
`ifdef SRAM_ARB_RR_EN
  // On contention the port that was not served last wins
  always_comb begin
    grant = req_valid;
    if (&req_valid) grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Port 0 wins whenever it is valid; port 1 may starve
  always_comb begin
    grant = req_valid;
    if (req_valid[0]) grant = 2'b01;
  end
`endif
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between two valid/ready requesters.
// Sequences fixed-timing read/write cycles; every SRAM pin comes from a flop.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1   // ACCESS length, 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data_in,
  output logic [DATA_W-1:0] sram_data_out,
  output logic              sram_data_oe,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  port_id_t          id_q, id_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d, rdata_q, rdata_d;
  logic [1:0]        rsp_q, rsp_d;
  logic              cs_q, cs_d, oe_q, oe_d, we_q, we_d, doe_q, doe_d;
  logic [1:0]        grant;
  logic              accept;
  port_id_t          acc_id;

  sram_arb_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];

  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_q;
  assign rsp_rdata     = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_data_out = dout_q;
  assign sram_data_oe  = doe_q;
  assign sram_cs       = cs_q;
  assign sram_oe       = oe_q;
  assign sram_we       = we_q;

  // Next state, captured request, and pin levels for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    id_d    = id_q;
    last_d  = last_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    rsp_d   = 2'b00;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        is_wr_d = req_we[acc_id];
        id_d    = acc_id;
        last_d  = acc_id;
        addr_d  = acc_id ? req_addr1 : req_addr0;
        dout_d  = acc_id ? req_wdata1 : req_wdata0;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = FINISH;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FINISH: begin
        state_d      = IDLE;
        rsp_d[id_q]  = 1'b1;
        rdata_d      = is_wr_q ? '0 : sram_data_in;
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered, so decode them from the state about to be entered
    cs_d  = 1'b1;
    oe_d  = 1'b1;
    we_d  = 1'b1;
    doe_d = 1'b0;
    if (state_d != IDLE) begin
      cs_d = 1'b0;
      if (is_wr_d) begin
        doe_d = 1'b1;
        we_d  = (state_d != ACCESS);
      end else begin
        oe_d = 1'b0;
      end
    end
  end

  // State and pin registers; reset parks the SRAM deselected immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      rsp_q   <= 2'b00;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      id_q    <= id_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      doe_q   <= doe_d;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: two arbiters (WAIT_CYCLES=1 and 3) with an SRAM model each,
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    req_valid [2], req_ready [2], req_we [2], rsp_valid [2];
  logic [AW-1:0] req_addr0 [2], req_addr1 [2], sram_addr [2];
  logic [DW-1:0] req_wdata0 [2], req_wdata1 [2], rsp_rdata [2];
  logic [DW-1:0] sram_data_in [2], sram_data_out [2];
  logic          busy [2], sram_data_oe [2], sram_cs [2], sram_oe [2], sram_we [2];
  int            W [2] = '{1, 3};

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [DW-1:0] smem [int];

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr0(req_addr0[g]), .req_addr1(req_addr1[g]),
      .req_wdata0(req_wdata0[g]), .req_wdata1(req_wdata1[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .busy(busy[g]),
      .sram_addr(sram_addr[g]), .sram_data_in(sram_data_in[g]),
      .sram_data_out(sram_data_out[g]), .sram_data_oe(sram_data_oe[g]),
      .sram_cs(sram_cs[g]), .sram_oe(sram_oe[g]), .sram_we(sram_we[g])
    );

    // Async SRAM: stores while selected with WE low and bus driven; drives the bus only with CS/OE low
    initial begin : sram_model
      int a;
      sram_data_in[g] = '0;
      forever begin
        @(posedge clk);
        a = int'(sram_addr[g]);
        if (rst_n && !sram_cs[g] && !sram_we[g] && sram_data_oe[g]) smem[a] = sram_data_out[g];
        #2;
        a = int'(sram_addr[g]);
        if (!sram_cs[g] && !sram_oe[g]) sram_data_in[g] = smem.exists(a) ? smem[a] : '0;
        else                            sram_data_in[g] = DW'($urandom);
      end
    end
  end

  int checks = 0, failures = 0;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Requester queues (index inst*2+port) and DUT-observed logs for the directed checks
  txn_t pq [4][$];
  int   acc_cyc [2][$];
  bit   acc_port [2][$];
  int   rsp_cyc [2][$];
  bit   rsp_port [2][$];
  logic [DW-1:0] rsp_dat [2][$];
  int   n_welow [2], n_oelow [2], n_doe [2], welow_first [2];

  // Requesters: present the queue head, hold it until valid&ready at an edge
  initial begin : driver
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = '0; req_we[i] = '0;
      req_addr0[i] = '0; req_addr1[i] = '0; req_wdata0[i] = '0; req_wdata1[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (rst_n && req_valid[i][p] && req_ready[i][p]) begin
            void'(pq[i*2+p].pop_front());
            acc_cyc[i].push_back(cyc);
            acc_port[i].push_back(1'(p));
          end
      #1;
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (pq[i*2+p].size() > 0) begin
            t = pq[i*2+p][0];
            req_we[i][p] = t.we;
            if (p == 0) begin req_addr0[i] = t.addr; req_wdata0[i] = t.data; end
            else        begin req_addr1[i] = t.addr; req_wdata1[i] = t.data; end
            req_valid[i][p] = 1'b1;
          end else begin
            req_valid[i][p] = 1'b0;
          end
    end
  end

  // Transaction-level model: one outstanding transaction, fixed offsets from its accept cycle
  int            m_free [2], m_acc [2];
  bit            m_has [2], m_ptr [2], m_port [2], m_wr [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd [2], m_rd [2];
  logic [DW-1:0] ref_mem [int];
  logic          p_cs [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_dout [2];

  function automatic logic [1:0] exp_grant(logic [1:0] v, bit last);
    if (v == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
      return last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  // Compare DUT outputs against the model every cycle, then advance the model
  always @(negedge clk) begin : cmp
    int k, key;
    bit act, p;
    logic [1:0] v, rdy;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        check("rst_cs", 32'(sram_cs[i]), 32'd1);
        check("rst_oe", 32'(sram_oe[i]), 32'd1);
        check("rst_we", 32'(sram_we[i]), 32'd1);
        check("rst_data_oe", 32'(sram_data_oe[i]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
        check("rst_busy", 32'(busy[i]), 32'd0);
        check("rst_addr", 32'(sram_addr[i]), 32'd0);
        m_free[i] = cyc; m_has[i] = 0; m_ptr[i] = 1; m_addr[i] = '0;
        p_cs[i] = 1'b1;
      end else begin
        k   = cyc - m_acc[i];
        act = m_has[i] && k >= 1 && cyc < m_free[i];
        check("cs", 32'(sram_cs[i]), 32'(!act));
        check("busy", 32'(busy[i]), 32'(act));
        check("oe", 32'(sram_oe[i]), 32'(!(act && !m_wr[i])));
        check("data_oe", 32'(sram_data_oe[i]), 32'(act && m_wr[i]));
        check("we", 32'(sram_we[i]), 32'(!(act && m_wr[i] && k >= 2 && k <= W[i] + 1)));
        check("sram_addr", 32'(sram_addr[i]), 32'(m_addr[i]));
        if (act && m_wr[i]) check("data_out", 32'(sram_data_out[i]), 32'(m_wd[i]));
        check("rsp_valid", 32'(rsp_valid[i]),
              32'((m_has[i] && cyc == m_free[i]) ? (m_port[i] ? 2'b10 : 2'b01) : 2'b00));
        if (m_has[i] && cyc == m_free[i]) check("rsp_rdata", 32'(rsp_rdata[i]), 32'(m_rd[i]));
        if (!p_cs[i] && !sram_cs[i]) begin
          check("stable_addr", 32'(sram_addr[i]), 32'(p_addr[i]));
          check("stable_data", 32'(sram_data_out[i]), 32'(p_dout[i]));
        end
        v   = req_valid[i];
        rdy = (cyc >= m_free[i]) ? exp_grant(v, m_ptr[i]) : 2'b00;
        check("req_ready", 32'(req_ready[i]), 32'(rdy));
        if (|(v & rdy)) begin
          p = rdy[1];
          m_has[i] = 1; m_acc[i] = cyc; m_free[i] = cyc + 3 + W[i];
          m_port[i] = p; m_ptr[i] = p; m_wr[i] = req_we[i][p];
          m_addr[i] = p ? req_addr1[i] : req_addr0[i];
          m_wd[i]   = p ? req_wdata1[i] : req_wdata0[i];
          key = (i << AW) | int'(m_addr[i]);
          if (m_wr[i]) begin ref_mem[key] = m_wd[i]; m_rd[i] = '0; end
          else m_rd[i] = ref_mem.exists(key) ? ref_mem[key] : '0;
        end
        if (!sram_cs[i] && !sram_we[i]) begin
          if (welow_first[i] < 0) welow_first[i] = cyc;
          n_welow[i]++;
        end
        if (!sram_cs[i] && !sram_oe[i]) n_oelow[i]++;
        if (sram_data_oe[i]) n_doe[i]++;
        if (rsp_valid[i] != 2'b00) begin
          rsp_cyc[i].push_back(cyc);
          rsp_port[i].push_back(rsp_valid[i][1]);
          rsp_dat[i].push_back(rsp_rdata[i]);
        end
        p_cs[i] = sram_cs[i]; p_addr[i] = sram_addr[i]; p_dout[i] = sram_data_out[i];
      end
    end
  end

  task automatic push(int i, int p, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    pq[i*2+p].push_back(t);
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      acc_cyc[i].delete(); acc_port[i].delete();
      rsp_cyc[i].delete(); rsp_port[i].delete(); rsp_dat[i].delete();
      n_welow[i] = 0; n_oelow[i] = 0; n_doe[i] = 0; welow_first[i] = -1;
    end
  endtask

  task automatic wait_idle(string name);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 400) begin
      @(negedge clk); #1; n++;
      done = pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0 &&
             req_valid[0] == 2'b00 && req_valid[1] == 2'b00 && cyc > m_free[0] && cyc > m_free[1];
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : tests
    int n;
    logic [5:0] ord;
    clr();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_addr", 32'(sram_addr[0]), 32'd0);
    check("post_rst_rdata", 32'(rsp_rdata[0]), 32'd0);

    // 1: W=1 write
    clr(); push(0, 0, 1, 18'h00010, 16'hA5A5); wait_idle("t1");
    check("t1_n_acc", 32'(acc_cyc[0].size()), 32'd1);
    check("t1_n_rsp", 32'(rsp_cyc[0].size()), 32'd1);
    if (acc_cyc[0].size() == 1 && rsp_cyc[0].size() == 1) begin
      check("t1_latency", 32'(rsp_cyc[0][0] - acc_cyc[0][0]), 32'd4);
      check("t1_we_low_at", 32'(welow_first[0] - acc_cyc[0][0]), 32'd2);
      check("t1_rsp_port", 32'(rsp_port[0][0]), 32'd0);
    end
    check("t1_we_low_cycles", 32'(n_welow[0]), 32'd1);
    check("t1_data_oe_cycles", 32'(n_doe[0]), 32'd3);

    // 2: port 1 reads it back
    clr(); push(0, 1, 0, 18'h00010, 16'h0); wait_idle("t2");
    check("t2_n_rsp", 32'(rsp_cyc[0].size()), 32'd1);
    if (acc_cyc[0].size() == 1 && rsp_cyc[0].size() == 1) begin
      check("t2_latency", 32'(rsp_cyc[0][0] - acc_cyc[0][0]), 32'd4);
      check("t2_rdata", 32'(rsp_dat[0][0]), 32'hA5A5);
      check("t2_rsp_port", 32'(rsp_port[0][0]), 32'd1);
    end
    check("t2_oe_low_cycles", 32'(n_oelow[0]), 32'd3);

    // 3: both ports hold valid for three writes each
    clr();
    for (int j = 0; j < 3; j++) begin
      push(0, 0, 1, AW'(18'h100 + j), DW'(16'h1000 + j));
      push(0, 1, 1, AW'(18'h200 + j), DW'(16'h2000 + j));
    end
    wait_idle("t3");
    check("t3_n_acc", 32'(acc_port[0].size()), 32'd6);
    if (acc_port[0].size() == 6) begin
      for (int j = 0; j < 6; j++) ord[j] = acc_port[0][j];
`ifdef SRAM_ARB_RR_EN
      check("t3_order", 32'(ord), 32'(6'b101010));
`else
      check("t3_order", 32'(ord), 32'(6'b111000));
`endif
    end

    // 4: W=3, top address
    clr(); push(1, 0, 1, 18'h3FFFF, 16'hFFFF); push(1, 0, 0, 18'h3FFFF, 16'h0); wait_idle("t4");
    check("t4_we_low_cycles", 32'(n_welow[1]), 32'd3);
    check("t4_n_rsp", 32'(rsp_cyc[1].size()), 32'd2);
    if (acc_cyc[1].size() == 2 && rsp_cyc[1].size() == 2) begin
      check("t4_lat_wr", 32'(rsp_cyc[1][0] - acc_cyc[1][0]), 32'd6);
      check("t4_lat_rd", 32'(rsp_cyc[1][1] - acc_cyc[1][1]), 32'd6);
      check("t4_wr_rdata", 32'(rsp_dat[1][0]), 32'd0);
      check("t4_rd_rdata", 32'(rsp_dat[1][1]), 32'hFFFF);
    end

    // 5: reset during ACCESS of a write
    clr(); push(0, 0, 1, 18'h2AAAA, 16'h1234);
    n = 0;
    while (acc_cyc[0].size() == 0 && n < 50) begin @(negedge clk); n++; end
    check("t5_accepted", 32'(acc_cyc[0].size()), 32'd1);
    @(posedge clk); #1;
    check("t5_we_low_before", 32'(sram_we[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_we", 32'(sram_we[0]), 32'd1);
    check("t5_cs", 32'(sram_cs[0]), 32'd1);
    check("t5_data_oe", 32'(sram_data_oe[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_rsp", 32'(rsp_cyc[0].size()), 32'd0);
    clr(); push(0, 0, 1, 18'h00020, 16'h5555); push(0, 1, 0, 18'h00020, 16'h0); wait_idle("t5b");
    check("t5_n_rsp", 32'(rsp_cyc[0].size()), 32'd2);
    if (rsp_dat[0].size() == 2) check("t5_rdata", 32'(rsp_dat[0][1]), 32'h5555);

    // 6: port 0 streams four writes
    clr();
    for (int j = 0; j < 4; j++) push(0, 0, 1, AW'(18'h30 + j), DW'(16'hC000 + j));
    wait_idle("t6");
    check("t6_n_acc", 32'(acc_cyc[0].size()), 32'd4);
    if (acc_cyc[0].size() == 4)
      for (int j = 1; j < 4; j++) check("t6_acc_spacing", 32'(acc_cyc[0][j] - acc_cyc[0][j-1]), 32'd4);

    // Random traffic on both instances, checked by the model every cycle
    clr();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          repeat ($urandom_range(0, 4))
            push(i, p, 1'($urandom), ($urandom_range(0, 7) == 0) ? 18'h3FFFF : AW'($urandom_range(0, 63)),
                 DW'($urandom));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
